// File: rtl/md_unit_pkg.sv
// -----------------------------------------------------------------------------
// md_unit_pkg
//   Shared definitions for the E-stage multiply/divide unit.
//   - md_op_e      : 4-bit MDU operation codes carried down the pipeline
//   - is_start_op  : true for the ops that launch a multi-cycle computation
//   - is_div_op    : true for the divide flavours (selects the longer latency)
// -----------------------------------------------------------------------------
package md_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  function automatic logic is_start_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_timer.sv
// -----------------------------------------------------------------------------
// mdu_timer
//   Loadable down-counter that times an MDU operation.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     load       : load load_val this edge (only asserted while idle)
//     load_val   : number of busy cycles for the operation
//     busy       : counter is non-zero
//     done       : counter is 1, i.e. this edge is the last busy edge
// -----------------------------------------------------------------------------
module mdu_timer #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          busy,
  output logic          done
);

  logic [CW-1:0] count_q, count_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy = (count_q != '0);
  assign done = (count_q == CW'(1));

endmodule

// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit
//   Multi-cycle multiply/divide controller for the E stage. Owns HI/LO,
//   computes MULT/MULTU/DIV/DIVU results at start and commits them to HI/LO
//   after a fixed latency, serves MFHI/MFLO/MTHI/MTLO, and raises a stall
//   term for the hazard unit while an MDU instruction in D must wait.
//   Ports:
//     clk, rst_n : pipeline clock, asynchronous active-low reset
//     md_op_E    : MDU op of the instruction in E (md_op_e codes)
//     a_E, b_E   : forwarded rs / rt values in E
//     md_use_D   : instruction in D is any MDU op
//     busy       : computation in progress
//     md_stall   : stall request to the hazard unit
//     rd_data    : MFHI/MFLO read data (0 for other ops)
//     hi, lo     : committed HI/LO registers
// -----------------------------------------------------------------------------
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       md_op_E,
  input  logic [WIDTH-1:0] a_E,
  input  logic [WIDTH-1:0] b_E,
  input  logic             md_use_D,
  output logic             busy,
  output logic             md_stall,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic             start;
  logic             done;
  logic [CW-1:0]    load_val;

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;  // 0 after divide-by-zero: leave HI/LO alone

  logic [WIDTH-1:0] res_hi, res_lo;
  logic             res_wr;

  assign start    = ~busy & is_start_op(md_op_E);
  assign load_val = is_div_op(md_op_E) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

  mdu_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start),
    .load_val (load_val),
    .busy     (busy),
    .done     (done)
  );

  // Result of the op currently in E; only captured on the start edge.
  always_comb begin
    logic [2*WIDTH-1:0] prod;
    prod   = '0;
    res_hi = '0;
    res_lo = '0;
    res_wr = 1'b1;
    case (md_op_E)
      MD_MULT: begin
        prod = {{WIDTH{a_E[WIDTH-1]}}, a_E} * {{WIDTH{b_E[WIDTH-1]}}, b_E};
        {res_hi, res_lo} = prod;
      end
      MD_MULTU: begin
        prod = {{WIDTH{1'b0}}, a_E} * {{WIDTH{1'b0}}, b_E};
        {res_hi, res_lo} = prod;
      end
      MD_DIV: begin
        if (b_E == '0) begin
          res_wr = 1'b0;
        end else if ((a_E == INT_MIN) && (b_E == '1)) begin
          // Quotient overflows; wrap to INT_MIN with zero remainder.
          res_lo = INT_MIN;
          res_hi = '0;
        end else begin
          res_lo = WIDTH'($signed(a_E) / $signed(b_E));
          res_hi = WIDTH'($signed(a_E) % $signed(b_E));
        end
      end
      MD_DIVU: begin
        if (b_E == '0) begin
          res_wr = 1'b0;
        end else begin
          res_lo = a_E / b_E;
          res_hi = a_E % b_E;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (start) begin
      pend_hi_d = res_hi;
      pend_lo_d = res_lo;
      pend_wr_d = res_wr;
    end

    // done only while busy and MT only while idle, so these never overlap.
    if (done) begin
      if (pend_wr_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (!busy) begin
      if (md_op_E == MD_MTHI) hi_d = a_E;
      if (md_op_E == MD_MTLO) lo_d = a_E;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  // Reads see committed HI/LO only; a pending result is never bypassed.
  always_comb begin
    rd_data = '0;
    if (md_op_E == MD_MFHI) rd_data = hi_q;
    if (md_op_E == MD_MFLO) rd_data = lo_q;
  end

  // start is included because busy only rises after the start edge.
  assign md_stall = md_use_D & (start | busy);
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  md_op_E = 4'd0;
  logic [31:0] a_E = '0;
  logic [31:0] b_E = '0;
  logic        md_use_D = 1'b0;
  logic        busy, md_stall;
  logic [31:0] rd_data, hi, lo;

  int tests = 0;
  int fails = 0;

  md_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .md_op_E  (md_op_E),
    .a_E      (a_E),
    .b_E      (b_E),
    .md_use_D (md_use_D),
    .busy     (busy),
    .md_stall (md_stall),
    .rd_data  (rd_data),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op_E = op;
    a_E     = a;
    b_E     = b;
  endtask

  // Issue a start op, count busy cycles, require HI/LO held until busy falls.
  task automatic run_op(input string name, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int n,
                        input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    bit held;
    set_op(op, a, b);
    step();
    set_op(MD_NONE, '0, '0);
    cyc  = 0;
    held = 1'b1;
    while (busy === 1'b1 && cyc < 50) begin
      if (hi !== old_hi || lo !== old_lo) held = 1'b0;
      cyc++;
      step();
    end
    tests++;
    if (cyc != n) begin
      fails++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, cyc, n);
    end
    tests++;
    if (!held) begin
      fails++;
      $display("FAIL %s early_commit: hi/lo changed while busy (expected %h/%h)", name, old_hi, old_lo);
    end
    tests++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      fails++;
      $display("FAIL %s result: got hi=%h lo=%h expected hi=%h lo=%h", name, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || md_stall !== 1'b0 || rd_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: got busy=%b hi=%h lo=%h stall=%b rd=%h expected 0", busy, hi, lo, md_stall, rd_data);
    end
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_mult();
    run_op("mult_neg", MD_MULT,  32'hFFFFFFFE, 32'd3, 5, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu",    MD_MULTU, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 32'h00000002, 32'hFFFFFFFA);
  endtask

  task automatic test_div();
    run_op("div_neg",  MD_DIV,  32'hFFFFFFF9, 32'd2, 10, 32'h00000002, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_ovf",  MD_DIV,  32'h80000000, 32'hFFFFFFFF, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0, 32'h80000000);
    run_op("divu_by0", MD_DIVU, 32'd7, 32'd0, 10, 32'h0, 32'h80000000, 32'h0, 32'h80000000);
  endtask

  task automatic test_stall();
    int cyc;
    bit ok;
    md_use_D = 1'b1;
    set_op(MD_MULT, 32'd5, 32'd6);
    #1;
    tests++;
    if (md_stall !== 1'b1) begin
      fails++;
      $display("FAIL stall_start_cycle: got %b expected 1", md_stall);
    end
    step();
    set_op(MD_NONE, '0, '0);
    cyc = 0;
    ok  = 1'b1;
    while (busy === 1'b1 && cyc < 50) begin
      if (md_stall !== 1'b1) ok = 1'b0;
      cyc++;
      step();
    end
    tests++;
    if (!ok || cyc != 5) begin
      fails++;
      $display("FAIL stall_busy: ok=%b cycles=%0d expected stall high for 5 cycles", ok, cyc);
    end
    tests++;
    if (md_stall !== 1'b0 || hi !== 32'h0 || lo !== 32'd30) begin
      fails++;
      $display("FAIL stall_after: got stall=%b hi=%h lo=%h expected 0/0/1e", md_stall, hi, lo);
    end

    md_use_D = 1'b0;
    set_op(MD_MULT, 32'd7, 32'd8);
    #1;
    ok = (md_stall === 1'b0);
    step();
    set_op(MD_NONE, '0, '0);
    cyc = 0;
    while (busy === 1'b1 && cyc < 50) begin
      if (md_stall !== 1'b0) ok = 1'b0;
      cyc++;
      step();
    end
    tests++;
    if (!ok || cyc != 5 || lo !== 32'd56) begin
      fails++;
      $display("FAIL stall_no_use: ok=%b cycles=%0d lo=%h expected stall low, 5 cycles, lo=38", ok, cyc, lo);
    end
  endtask

  task automatic test_mt_mf();
    int cyc;
    set_op(MD_MTHI, 32'hCAFEF00D, '0);
    step();
    set_op(MD_MTLO, 32'h12345678, '0);
    step();
    tests++;
    if (hi !== 32'hCAFEF00D || lo !== 32'h12345678) begin
      fails++;
      $display("FAIL mt_idle: got hi=%h lo=%h expected cafef00d/12345678", hi, lo);
    end
    set_op(MD_MFLO, '0, '0);
    #1;
    tests++;
    if (rd_data !== 32'h12345678) begin
      fails++;
      $display("FAIL mflo: got %h expected 12345678", rd_data);
    end
    set_op(MD_MFHI, '0, '0);
    #1;
    tests++;
    if (rd_data !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL mfhi: got %h expected cafef00d", rd_data);
    end
    set_op(MD_NONE, '0, '0);
    #1;
    tests++;
    if (rd_data !== 32'h0) begin
      fails++;
      $display("FAIL rd_other_op: got %h expected 0", rd_data);
    end

    set_op(MD_MULT, 32'd2, 32'd3);
    step();
    set_op(MD_MTHI, 32'hDEADBEEF, '0);
    step();
    tests++;
    if (busy !== 1'b1 || hi !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL mthi_busy: got busy=%b hi=%h expected 1/cafef00d", busy, hi);
    end
    set_op(MD_NONE, '0, '0);
    cyc = 0;
    while (busy === 1'b1 && cyc < 50) begin
      cyc++;
      step();
    end
    tests++;
    if (hi !== 32'h0 || lo !== 32'd6) begin
      fails++;
      $display("FAIL mult_after_mt: got hi=%h lo=%h expected 0/6", hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    set_op(MD_DIV, 32'd100, 32'd7);
    step();
    set_op(MD_NONE, '0, '0);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid_op: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    end
    #1 rst_n = 1'b1;
    step();
    run_op("mult_after_reset", MD_MULT, 32'hFFFFFFFE, 32'd3, 5, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA);
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit ok;
    md_use_D = 1'b1;
    set_op(MD_MULT, 32'd3, 32'd4);
    step();
    // The DIV sits in E while the MULT is busy and must be ignored.
    set_op(MD_DIV, 32'hFFFFFFF9, 32'd2);
    cyc = 0;
    ok  = 1'b1;
    while (busy === 1'b1 && cyc < 50) begin
      if (md_stall !== 1'b1) ok = 1'b0;
      cyc++;
      step();
    end
    tests++;
    if (!ok || cyc != 5 || hi !== 32'h0 || lo !== 32'd12) begin
      fails++;
      $display("FAIL b2b_mult: ok=%b cycles=%0d hi=%h lo=%h expected stall, 5 cycles, 0/c", ok, cyc, hi, lo);
    end
    step();
    set_op(MD_NONE, '0, '0);
    md_use_D = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_div_start: got busy=%b expected 1", busy);
    end
    cyc = 0;
    while (busy === 1'b1 && cyc < 50) begin
      cyc++;
      step();
    end
    tests++;
    if (cyc != 10 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      fails++;
      $display("FAIL b2b_div: cycles=%0d hi=%h lo=%h expected 10, ffffffff/fffffffd", cyc, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_stall();
    test_mt_mf();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
